// File: rtl/memory_responder.sv
// Wait-state memory responder: captures one read or write request in IDLE,
// stalls WAIT_CYCLES cycles, performs the access and pulses Done.
module memory_responder #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned DEPTH       = 512
) (
  input  logic        clock_i,
  input  logic        clear_n_i,
  input  logic        read_i,
  input  logic        write_i,
  input  logic [8:0]  address_i,
  input  logic [31:0] data_in_i,
  output logic [31:0] mdatain_o,
  output logic        done_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t         state_q;
  logic [3:0]     cnt_q;
  logic [8:0]     addr_q;
  logic [31:0]    data_q;
  logic           is_wr_q;
  logic [31:0]    mdata_q;
  logic           done_q;
  logic           busy_q;
  logic           err_q;
  logic [AW-1:0]  mem_idx_s;
  logic [31:0]    mem_q [DEPTH];

  // Out-of-range addresses wrap onto the physical array.
  assign mem_idx_s = AW'(32'(addr_q) % DEPTH);

  // Request FSM with registered status outputs and read-data register.
  always_ff @(posedge clock_i or negedge clear_n_i) begin
    if (!clear_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 9'd0;
      data_q  <= 32'd0;
      is_wr_q <= 1'b0;
      mdata_q <= 32'd0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (read_i ^ write_i) begin
            addr_q  <= address_i;
            data_q  <= data_in_i;
            is_wr_q <= write_i;
            busy_q  <= 1'b1;
            cnt_q   <= 4'(WAIT_CYCLES);
            state_q <= (WAIT_CYCLES == 32'd0) ? S_ACCESS : S_WAIT;
          end else if (read_i && write_i) begin
            err_q <= 1'b1;
          end else begin
            busy_q <= 1'b0;
          end
        end
        S_WAIT: begin
          if (cnt_q <= 4'd1) begin
            cnt_q   <= 4'd0;
            state_q <= S_ACCESS;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_ACCESS: begin
          if (!is_wr_q) begin
            mdata_q <= mem_q[mem_idx_s];
          end else begin
            mdata_q <= mdata_q;
          end
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Storage is never reset; a reset aborts the access by forcing state to IDLE.
  always_ff @(posedge clock_i) begin
    if (state_q == S_ACCESS && is_wr_q) begin
      mem_q[mem_idx_s] <= data_q;
    end
  end

  assign mdatain_o = mdata_q;
  assign done_o    = done_q;
  assign busy_o    = busy_q;
  assign err_o     = err_q;

endmodule

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 1, giving wait states before each access (legal 0..15).
REQ-002 The block SHALL have parameter DEPTH, default 512, giving the word count of the internal 32-bit memory.
REQ-003 Clock  input  1  single system clock; all state changes occur on its rising edge.
REQ-004 Clear  input  1  reset, asynchronous, active-low.
REQ-005 Read  input  1  read request from the datapath.
REQ-006 Write  input  1  write request from the datapath.
REQ-007 Address  input  9  word address from MAR[8:0].
REQ-008 DataIn  input  32  write data from MDR_data_out.
REQ-009 Mdatain  output  32  registered read data to the MDR input mux.
REQ-010 Done  output  1  one-cycle completion pulse, for both reads and writes.
REQ-011 Busy  output  1  high while a request is in progress.
REQ-012 Err  output  1  one-cycle pulse flagging an illegal request.

Function
REQ-013 The FSM SHALL have states IDLE, WAIT, ACCESS and DONE, and SHALL reset to IDLE.
REQ-014 In IDLE, a rising edge with exactly one of Read/Write high SHALL capture Address, DataIn and the direction.
- Next state is WAIT if WAIT_CYCLES>0, else ACCESS.
REQ-015 WAIT SHALL last exactly WAIT_CYCLES cycles, counted by a 4-bit counter loaded at capture, then go to ACCESS.
REQ-016 On the edge leaving ACCESS:
- a read SHALL register mem[captured address] into Mdatain;
- a write SHALL store the captured DataIn into mem[captured address];
- the state SHALL go to DONE with Done=1.
REQ-017 DONE SHALL last one cycle; Done SHALL then fall and the state SHALL return to IDLE.
REQ-018 Done SHALL first be high W+1 edges after the capture edge (W = WAIT_CYCLES), for exactly one cycle.
REQ-019 Busy SHALL be 1 exactly in WAIT, ACCESS and DONE.
REQ-020 Requests SHALL be sampled only in IDLE; Read/Write edges in any other state SHALL be ignored, with no queuing and no error.
REQ-021 Read and Write both high in IDLE SHALL perform no access, pulse Err for one cycle and leave the FSM in IDLE.
REQ-022 Mdatain SHALL hold its last read value through writes, errors and idle cycles.
REQ-023 Mdatain SHALL change only on completion of a read.
REQ-024 Data changes on Address/DataIn after the capture edge SHALL NOT affect the in-flight access.
REQ-025 Read-after-write to the same address SHALL return the newly written data, with no forwarding hazard.
REQ-026 Addresses at or above DEPTH SHALL wrap modulo DEPTH.

Reset
REQ-027 While Clear=0, Mdatain, Done, Busy, Err and the wait counter SHALL be 0 and the state SHALL be IDLE, independent of Clock.
REQ-028 Reset assertion in WAIT or ACCESS SHALL abort the access: no memory write is committed and Mdatain is cleared to 0.
REQ-029 Memory contents SHALL NOT be cleared by reset.
REQ-030 The first request SHALL be accepted on the first rising edge after Clear returns high.

Verification
REQ-031 Write-then-read, W=1: write 0x28918000 to address 0x010, then read 0x010 -> Done on the 2nd edge after each capture and Mdatain=0x28918000.
REQ-032 Read latency, W=3: preload mem[0x012]=0x00000012, read 0x012 -> Busy high for 5 cycles, Done on the 4th edge after capture, Mdatain=0x00000012.
REQ-033 Zero-wait, W=0: read mem[0x014]=0x00000014 -> Done on the 1st edge after capture.
REQ-034 Collision: Read=Write=1 in IDLE -> Err pulses one cycle, Done stays 0, memory and Mdatain unchanged.
REQ-035 Busy-ignore: a second Read to 0x018 asserted during WAIT of a read to 0x012 -> only one Done, Mdatain=mem[0x012].
REQ-036 Reset mid-write: write 0xDEADBEEF to 0x020 over old value 0x00000018, Clear=0 during WAIT -> all outputs 0 immediately and a later read of 0x020 returns 0x00000018.
